// File: rtl/temp_sample_averager.sv
// temp_sample_averager
//   Conditions raw die-temperature ADC responses for the display FIFO.
//   It accepts samples for one ADC channel when the sample-rate strobe is
//   high, and averages 2**LOG2_AVG of them. It then removes the display
//   offset, saturates the result to 9 bits and hands the word downstream
//   with a valid/ready handshake. Qualifying samples that arrive while a
//   result is pending are counted in a sticky drop counter.
//
// Ports
//   clock        in   1   system clock, rising edge
//   reset        in   1   synchronous, active-high
//   sample_tick  in   1   one-cycle sample-rate strobe
//   adc_valid    in   1   ADC response valid
//   adc_channel  in   5   ADC response channel
//   adc_data     in   12  ADC response data, unsigned
//   out_ready    in   1   downstream can take a word
//   out_valid    out  1   out_data holds a finished result
//   out_data     out  9   offset-corrected, saturated average
//   busy         out  1   high in any state other than IDLE
//   drop_count   out  8   samples discarded while a result is pending, sticky at 255
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for the first sample of an average
// ACCUM | summing the remaining samples of the average
// CALC  | one cycle: scale, offset and saturate the sum into out_data
// HOLD  | result presented; waiting for out_ready

module temp_sample_averager #(
  parameter logic [4:0]  CHANNEL  = 5'd17,
  parameter int          LOG2_AVG = 2,
  parameter logic [11:0] OFFSET   = 12'd3431
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_tick,
  input  logic        adc_valid,
  input  logic [4:0]  adc_channel,
  input  logic [11:0] adc_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [8:0]  out_data,
  output logic        busy,
  output logic [7:0]  drop_count
);

  // The accumulator is wide enough for 2**LOG2_AVG full-scale samples.
  localparam int ACC_W = 12 + LOG2_AVG;
  localparam int CNT_W = LOG2_AVG + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << LOG2_AVG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CALC  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic        qualify;
  logic        accept;
  logic        drop;
  logic [11:0] mean;
  logic [11:0] excess;
  logic [8:0]  res;

  assign qualify = sample_tick && adc_valid && (adc_channel == CHANNEL);
  assign accept  = qualify && ((state == IDLE) || (state == ACCUM));
  // A sample that arrives on the HOLD->IDLE transfer edge is still seen
  // in HOLD, so it is dropped rather than starting a new average.
  assign drop    = qualify && ((state == CALC) || (state == HOLD));
  assign busy    = (state != IDLE);

  // Dividing by a power of two truncates the mean. The excess is only
  // meaningful when mean >= OFFSET, which is checked first.
  always_comb begin
    mean   = 12'(acc >> LOG2_AVG);
    excess = mean - OFFSET;
    if (mean < OFFSET) begin
      res = 9'd0;
    end else if (excess > 12'd511) begin
      res = 9'd511;
    end else begin
      res = excess[8:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      drop_count <= '0;
    end else begin
      if (drop && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end

      unique case (state)
        IDLE: begin
          if (accept) begin
            acc   <= ACC_W'(adc_data);
            cnt   <= CNT_ONE;
            state <= (LOG2_AVG == 0) ? CALC : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= acc + ACC_W'(adc_data);
            cnt <= cnt + CNT_ONE;
            if ((cnt + CNT_ONE) == CNT_FULL) begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          out_data  <= res;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temp_sample_averager.sv
// Testbench for temp_sample_averager (LOG2_AVG=2, OFFSET=3431, CHANNEL=17).
// Inputs are driven and outputs are sampled on the falling clock edge.

module tb_temp_sample_averager;

  logic        clock = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic        adc_valid;
  logic [4:0]  adc_channel;
  logic [11:0] adc_data;
  logic        out_ready;
  logic        out_valid;
  logic [8:0]  out_data;
  logic        busy;
  logic [7:0]  drop_count;

  int n_cmp     = 0;
  int n_bad     = 0;
  int n_xfer    = 0;
  int exp_drops = 0;

  temp_sample_averager #(
    .CHANNEL  (5'd17),
    .LOG2_AVG (2),
    .OFFSET   (12'd3431)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sample_tick (sample_tick),
    .adc_valid   (adc_valid),
    .adc_channel (adc_channel),
    .adc_data    (adc_data),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .busy        (busy),
    .drop_count  (drop_count)
  );

  always #5 clock = ~clock;

  // Count handshake transfers independently of the checks.
  always @(posedge clock) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) n_xfer++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string             name;
    logic [3:0][11:0]  s;
    int                expv;
  } vec_t;

  vec_t tbl[6];

  // Reference: integer mean of four samples, offset removed, clamped to 0..511.
  function automatic int ref_avg(input int a, input int b, input int c, input int d);
    int mean;
    int r;
    mean = (a + b + c + d) / 4;
    if (mean < 3431) return 0;
    r = mean - 3431;
    return (r > 511) ? 511 : r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Called on a falling edge; applies inputs for one rising edge and
  // returns on the following falling edge with inputs idle.
  task automatic drive(input logic tk, input logic vl, input logic [4:0] ch, input logic [11:0] d);
    sample_tick = tk;
    adc_valid   = vl;
    adc_channel = ch;
    adc_data    = d;
    @(posedge clock);
    @(negedge clock);
    sample_tick = 1'b0;
    adc_valid   = 1'b0;
    adc_channel = 5'd0;
    adc_data    = 12'd0;
  endtask

  task automatic run_avg(input string name, input logic [3:0][11:0] s, input int expv,
                         input int ready_delay, input bit junk);
    int x0;
    x0 = n_xfer;
    out_ready = (ready_delay == 0);
    for (int i = 0; i < 4; i++) begin
      if (junk) begin
        drive(1'b1, 1'b1, 5'($urandom_range(0, 16)), 12'($urandom));
        drive(1'b0, 1'b1, 5'd17, 12'($urandom));
      end
      drive(1'b1, 1'b1, 5'd17, s[i]);
    end
    check({name, " calc out_valid"}, out_valid, 0);
    check({name, " calc busy"}, busy, 1);
    drive(1'b0, 1'b0, 5'd0, 12'd0);
    check({name, " hold out_valid"}, out_valid, 1);
    check({name, " out_data"}, out_data, expv);
    for (int k = 0; k < ready_delay; k++) drive(1'b0, 1'b0, 5'd0, 12'd0);
    if (ready_delay > 0) begin
      check({name, " stall out_valid"}, out_valid, 1);
      check({name, " stall out_data"}, out_data, expv);
      out_ready = 1'b1;
    end
    drive(1'b0, 1'b0, 5'd0, 12'd0);
    check({name, " post out_valid"}, out_valid, 0);
    check({name, " post busy"}, busy, 0);
    check({name, " transfers"}, n_xfer - x0, 1);
    check({name, " drop_count"}, drop_count, exp_drops);
  endtask

  initial begin
    logic [3:0][11:0] rs;
    int x0;

    reset       = 1'b1;
    sample_tick = 1'b0;
    adc_valid   = 1'b0;
    adc_channel = 5'd0;
    adc_data    = 12'd0;
    out_ready   = 1'b0;
    repeat (2) @(negedge clock);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset busy", busy, 0);
    check("reset drop_count", drop_count, 0);
    reset = 1'b0;

    tbl[0] = '{name: "T1 nominal",   s: {12'd3500, 12'd3500, 12'd3500, 12'd3500}, expv: 69};
    tbl[1] = '{name: "T2 truncate",  s: {12'd3434, 12'd3433, 12'd3432, 12'd3431}, expv: 1};
    tbl[2] = '{name: "T3 low clamp", s: {12'd3000, 12'd3000, 12'd3000, 12'd3000}, expv: 0};
    tbl[3] = '{name: "T3 high clamp", s: {12'd4000, 12'd4000, 12'd4000, 12'd4000}, expv: 511};
    tbl[4] = '{name: "at offset",    s: {12'd3431, 12'd3431, 12'd3431, 12'd3431}, expv: 0};
    tbl[5] = '{name: "edge 512",     s: {12'd3943, 12'd3943, 12'd3943, 12'd3943}, expv: 511};

    for (int i = 0; i < 6; i++) run_avg(tbl[i].name, tbl[i].s, tbl[i].expv, 0, 1'b0);

    run_avg("T4 filter", {12'd3600, 12'd3600, 12'd3600, 12'd3600}, 169, 0, 1'b1);

    // A qualifying sample on the transfer edge is dropped, not accepted.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 5'd17, 12'd3500);
    drive(1'b0, 1'b0, 5'd0, 12'd0);
    check("simul hold out_valid", out_valid, 1);
    drive(1'b1, 1'b1, 5'd17, 12'd3600);
    exp_drops = 1;
    check("simul drop_count", drop_count, exp_drops);
    check("simul busy", busy, 0);
    check("simul out_valid", out_valid, 0);

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 4; i++) rs[i] = 12'($urandom_range(2900, 4095));
      run_avg("random", rs, ref_avg(rs[0], rs[1], rs[2], rs[3]),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // T5: back-pressure with a flood of samples.
    x0 = n_xfer;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 5'd17, 12'd3500);
    drive(1'b0, 1'b0, 5'd0, 12'd0);
    for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, 5'd17, 12'd3500);
    check("T5 out_valid", out_valid, 1);
    check("T5 out_data", out_data, 69);
    check("T5 drop_count", drop_count, 255);
    check("T5 busy", busy, 1);
    check("T5 no transfer", n_xfer - x0, 0);
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 12'd0);
    check("T5 released out_valid", out_valid, 0);
    check("T5 released busy", busy, 0);
    check("T5 transfers", n_xfer - x0, 1);
    check("T5 drop sticky", drop_count, 255);

    // T6: reset in the middle of an average.
    drive(1'b1, 1'b1, 5'd17, 12'd4000);
    drive(1'b1, 1'b1, 5'd17, 12'd4000);
    check("T6 busy pre-reset", busy, 1);
    reset = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 12'd0);
    reset = 1'b0;
    exp_drops = 0;
    check("T6 reset busy", busy, 0);
    check("T6 reset out_valid", out_valid, 0);
    check("T6 reset out_data", out_data, 0);
    check("T6 reset drop_count", drop_count, 0);
    run_avg("T6 after reset", {12'd3440, 12'd3440, 12'd3440, 12'd3440}, 9, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
